dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Shares the single-port data memory between two requesters: port 0, the core load/store unit, and port 1, the debug/DMA loader. Per port it runs a req/gnt handshake, arbitrates round-robin or fixed-priority, and supports locked read-modify-write sequences. It drives the memory write-enable, address and write-data pins, and registers read data and error status into a one-cycle-latency response. It sits between the core/debug masters and the data memory in the RISCV top level.

Parameters:
WIDTH, 32, data and address width
DEPTH, 8, memory depth in words; valid byte addresses are 0 .. 4*DEPTH-4
FIXED_PRIO, 0, 0 = round-robin; 1 = port 0 always wins

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
m0_req  in  1  port 0 request; held with its fields until granted
m0_we  in  1  port 0 write (1) / read (0)
m0_addr  in  WIDTH  port 0 byte address
m0_wdata  in  WIDTH  port 0 write data
m0_lock  in  1  port 0 keep ownership after this access
m0_gnt  out  1  port 0 accepted this cycle (combinational)
m0_rvalid  out  1  port 0 response valid, one cycle
m0_rdata  out  WIDTH  port 0 read data
m0_err  out  1  port 0 access error
m1_req, m1_we, m1_addr, m1_wdata, m1_lock, m1_gnt, m1_rvalid, m1_rdata, m1_err  same as port 0, for port 1
mem_we  out  1  memory write enable
mem_a  out  WIDTH  memory byte address
mem_wd  out  WIDTH  memory write data
mem_rd  in  WIDTH  memory read data, combinational from mem_a while mem_we=0

Behaviour:
- Reset (reset=0, asynchronous):
  - state = ARB; last-grant pointer = port 1, so port 0 wins the first tie.
  - All rvalid/err = 0; all rdata = 0.
  - mem_we = 0; mem_a = 0; mem_wd = 0.
- Handshake:
  - A port's transfer is accepted in a cycle where req=1 and gnt=1.
  - At most one gnt is high per cycle.
  - gnt is never high when req=0.
- Memory drive:
  - mem_* is driven combinationally from the granted port in the acceptance cycle.
  - With no grant: mem_we = 0, mem_a = 0, mem_wd = 0.
- Response:
  - The response follows acceptance by exactly 1 cycle; that port's rvalid is high for one cycle.
  - Read: rdata = mem_rd sampled at the acceptance edge.
  - Write: rdata = 0, rvalid still asserted as a write ack.
- Back-to-back: a new acceptance is allowed every cycle; response pipeline depth is 1, with no stall.
- Error check:
  - An access is in error if addr[1:0] != 0 or addr[WIDTH-1:2] >= DEPTH.
  - On error, gnt is still given, but mem_we is forced to 0 and mem_a = 0.
  - Next cycle: rvalid = 1, err = 1, rdata = 0.
- Arbitration in ARB:
  - One requester wins.
  - Both requesting with FIXED_PRIO=0: grant the port not in last-grant.
  - Both requesting with FIXED_PRIO=1: grant port 0.
  - last-grant updates on every acceptance.
- State machine (states ARB, LOCK0, LOCK1):
  - ARB -> LOCKn when port n is accepted with mn_lock=1 and no error.
  - In LOCKn only port n can be granted; the other port's gnt = 0 regardless of its req.
  - LOCKn -> ARB on acceptance of a port-n transfer with mn_lock=0.
  - An error access in LOCKn also returns to ARB.
- Asynchronous reset mid-operation: any pending response is discarded (no rvalid after reset), and the lock is released.

Decomposition:
- Shared package dmem_pkg holds:
  - state encoding: ARB=2'd0, LOCK0=2'd1, LOCK1=2'd2;
  - port index constants P0=1'b0, P1=1'b1.
- One natural sub-module, rr_arb2: a 2-input grant picker with last-grant pointer, FIXED_PRIO and an enable mask.
- Address check, lock FSM and response registers stay in dmem_arbiter.

Test Plan:
- Port 0 reads addr 0x0C -> m0_gnt=1 same cycle, mem_a=0x0C, mem_we=0; next cycle m0_rvalid=1, m0_rdata=3, m0_err=0.
- Port 1 writes 0xDEADBEEF to 0x10, then port 0 reads 0x10 -> m1_rvalid ack with m1_rdata=0; m0_rdata=0xDEADBEEF.
- Both request continuously for 4 cycles with FIXED_PRIO=0 -> grants P0,P1,P0,P1; with FIXED_PRIO=1 -> P0 ×4 and m1_gnt stays 0.
- Port 0 read 0x04 with lock=1, then write 0x04 with lock=0, while port 1 requests throughout -> m1_gnt=0 for both cycles; port 1 granted in the third cycle.
- Port 1 accesses 0x20 (out of range) and 0x06 (misaligned) -> mem_we=0 both times; m1_err=1, m1_rdata=0; memory contents unchanged.
- Drive reset low in the cycle after a port-0 read acceptance -> no m0_rvalid follows; all outputs return to 0; state returns to ARB.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: lock FSM encoding,
// port index constants and the per-state grant mask.
package dmem_pkg;

   // Lock state machine: ARB arbitrates freely, LOCKn reserves the memory for port n
   typedef enum logic [1:0] {
      ARB   = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } state_t;

   // Port indices, also used as the last-grant pointer value
   localparam logic P0 = 1'b0;
   localparam logic P1 = 1'b1;

   // Which ports may be granted in a given lock state (bit n = port n)
   function automatic logic [1:0] lock_mask(input state_t s);
      case (s)
         LOCK0:   return 2'b01;
         LOCK1:   return 2'b10;
         default: return 2'b11;
      endcase
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-input grant picker. Requests are first filtered by an enable mask
// (used by the lock FSM to exclude the non-owning port). On a tie the
// winner is either port 0 (fixed priority) or the port that did not win
// last (round-robin). The last-grant pointer lives here and advances on
// every grant, since a grant is always an accepted transfer.
module rr_arb2
   import dmem_pkg::*;
#(
   parameter int FIXED_PRIO = 0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] req,
   input  logic [1:0] en,
   output logic [1:0] gnt
);

   logic       last;
   logic [1:0] elig;

   assign elig = req & en;

   // Pick at most one winner among the eligible requesters
   always_comb begin
      gnt = 2'b00;
      if (elig == 2'b11) begin
         if ((FIXED_PRIO != 0) || (last == P1)) begin
            gnt = 2'b01;
         end else begin
            gnt = 2'b10;
         end
      end else begin
         gnt = elig;
      end
   end

   // Remember the most recent winner; reset points at port 1 so port 0 wins the first tie
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last <= P1;
      end else if (gnt[0]) begin
         last <= P0;
      end else if (gnt[1]) begin
         last <= P1;
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the core load/store unit (port 0) and the
// debug/DMA loader (port 1).
//
// Handshake: a master raises mN_req and holds its fields stable until it sees
// mN_gnt; the transfer is accepted in the cycle where req and gnt are both 1.
// gnt is combinational, at most one port is granted per cycle, and gnt is
// never raised without req. Exactly one cycle after acceptance that port's
// rvalid pulses for one cycle with rdata/err; a new transfer may be accepted
// every cycle.
//
// Accesses with a misaligned or out-of-range address are still granted but
// never reach the memory (mem_we/mem_a/mem_wd held at 0); they answer with
// err=1 and rdata=0. A locked access moves the FSM to LOCKn so that only
// port n can be granted until it issues an unlocked (or faulting) access.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 8,
   parameter int FIXED_PRIO = 0
) (
   input  logic             clk,
   input  logic             reset,
   // port 0: core load/store unit
   input  logic             m0_req,
   input  logic             m0_we,
   input  logic [WIDTH-1:0] m0_addr,
   input  logic [WIDTH-1:0] m0_wdata,
   input  logic             m0_lock,
   output logic             m0_gnt,
   output logic             m0_rvalid,
   output logic [WIDTH-1:0] m0_rdata,
   output logic             m0_err,
   // port 1: debug / DMA loader
   input  logic             m1_req,
   input  logic             m1_we,
   input  logic [WIDTH-1:0] m1_addr,
   input  logic [WIDTH-1:0] m1_wdata,
   input  logic             m1_lock,
   output logic             m1_gnt,
   output logic             m1_rvalid,
   output logic [WIDTH-1:0] m1_rdata,
   output logic             m1_err,
   // single-port data memory
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_a,
   output logic [WIDTH-1:0] mem_wd,
   input  logic [WIDTH-1:0] mem_rd,
   // lock FSM state, for observation
   output state_t           dbg_state
);

   // Number of words expressed in word-address width, for the range check
   localparam logic [WIDTH-3:0] DEPTH_W = (WIDTH-2)'(DEPTH);

   state_t           state;
   logic [1:0]       req;
   logic [1:0]       en;
   logic [1:0]       gnt;
   logic             acc;
   logic             sel;
   logic             sel_we;
   logic             sel_lock;
   logic             sel_err;
   logic [WIDTH-1:0] sel_addr;
   logic [WIDTH-1:0] sel_wdata;

   assign req       = {m1_req, m0_req};
   assign en        = lock_mask(state);
   assign dbg_state = state;

   rr_arb2 #(
      .FIXED_PRIO(FIXED_PRIO)
   ) u_arb (
      .clk  (clk),
      .reset(reset),
      .req  (req),
      .en   (en),
      .gnt  (gnt)
   );

   assign acc    = gnt[0] | gnt[1];
   assign sel    = gnt[1];
   assign m0_gnt = gnt[0];
   assign m1_gnt = gnt[1];

   // Route the winning port's transfer fields
   always_comb begin
      sel_we    = m0_we;
      sel_lock  = m0_lock;
      sel_addr  = m0_addr;
      sel_wdata = m0_wdata;
      if (sel == P1) begin
         sel_we    = m1_we;
         sel_lock  = m1_lock;
         sel_addr  = m1_addr;
         sel_wdata = m1_wdata;
      end
   end

   // Word alignment and range check on the selected address
   assign sel_err = (sel_addr[1:0] != 2'b00) || (sel_addr[WIDTH-1:2] >= DEPTH_W);

   // Drive the memory only for a granted, well-formed access
   always_comb begin
      mem_we = 1'b0;
      mem_a  = '0;
      mem_wd = '0;
      if (acc && !sel_err) begin
         mem_we = sel_we;
         mem_a  = sel_addr;
         mem_wd = sel_wdata;
      end
   end

   // Lock FSM: enter LOCKn on a clean locked access, leave on unlocked or faulting access
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ARB;
      end else if (acc) begin
         case (state)
            ARB: begin
               if (sel_lock && !sel_err) begin
                  state <= (sel == P1) ? LOCK1 : LOCK0;
               end
            end
            LOCK0, LOCK1: begin
               if (!sel_lock || sel_err) begin
                  state <= ARB;
               end
            end
            default: state <= ARB;
         endcase
      end
   end

   // Port 0 response: one-cycle pulse; data only for a clean read
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m0_rvalid <= 1'b0;
         m0_err    <= 1'b0;
         m0_rdata  <= '0;
      end else begin
         m0_rvalid <= gnt[0];
         m0_err    <= gnt[0] & sel_err;
         m0_rdata  <= (gnt[0] && !sel_err && !sel_we) ? mem_rd : '0;
      end
   end

   // Port 1 response: one-cycle pulse; data only for a clean read
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m1_rvalid <= 1'b0;
         m1_err    <= 1'b0;
         m1_rdata  <= '0;
      end else begin
         m1_rvalid <= gnt[1];
         m1_err    <= gnt[1] & sel_err;
         m1_rdata  <= (gnt[1] && !sel_err && !sel_we) ? mem_rd : '0;
      end
   end

   // Structural properties of the grant path
   a_one_hot_gnt : assert property (@(posedge clk) disable iff (!reset) !(gnt[0] && gnt[1]));
   a_gnt0_needs_req : assert property (@(posedge clk) disable iff (!reset) gnt[0] |-> m0_req);
   a_gnt1_needs_req : assert property (@(posedge clk) disable iff (!reset) gnt[1] |-> m1_req);
   a_err_no_write : assert property (@(posedge clk) disable iff (!reset) (acc && sel_err) |-> !mem_we);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: one round-robin and one fixed-priority instance
// driven by the same directed stimulus, each with its own memory, checked
// every cycle against a rule-level reference model plus literal spot checks.
module tb_dmem_arbiter;
   import dmem_pkg::*;

   localparam int W = 32;
   localparam int D = 8;

   // ---------------- clock / reset ----------------
   logic clk;
   logic reset;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- shared stimulus ----------------
   logic         m0_req, m0_we, m0_lock;
   logic [W-1:0] m0_addr, m0_wdata;
   logic         m1_req, m1_we, m1_lock;
   logic [W-1:0] m1_addr, m1_wdata;

   // ---------------- per-instance outputs (0 = round-robin, 1 = fixed) ----------------
   logic [1:0]   g0, g1, rv0, rv1, er0, er1, mwe;
   logic [W-1:0] rd0 [2];
   logic [W-1:0] rd1 [2];
   logic [W-1:0] ma  [2];
   logic [W-1:0] mwd [2];
   logic [W-1:0] mrd [2];
   state_t       dbg_st [2];

   dmem_arbiter #(.WIDTH(W), .DEPTH(D), .FIXED_PRIO(0)) u_rr (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_lock(m0_lock),
      .m0_gnt(g0[0]), .m0_rvalid(rv0[0]), .m0_rdata(rd0[0]), .m0_err(er0[0]),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
      .m1_gnt(g1[0]), .m1_rvalid(rv1[0]), .m1_rdata(rd1[0]), .m1_err(er1[0]),
      .mem_we(mwe[0]), .mem_a(ma[0]), .mem_wd(mwd[0]), .mem_rd(mrd[0]),
      .dbg_state(dbg_st[0])
   );

   dmem_arbiter #(.WIDTH(W), .DEPTH(D), .FIXED_PRIO(1)) u_fp (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_lock(m0_lock),
      .m0_gnt(g0[1]), .m0_rvalid(rv0[1]), .m0_rdata(rd0[1]), .m0_err(er0[1]),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_lock(m1_lock),
      .m1_gnt(g1[1]), .m1_rvalid(rv1[1]), .m1_rdata(rd1[1]), .m1_err(er1[1]),
      .mem_we(mwe[1]), .mem_a(ma[1]), .mem_wd(mwd[1]), .mem_rd(mrd[1]),
      .dbg_state(dbg_st[1])
   );

   // ---------------- memories attached to each instance ----------------
   logic [W-1:0] bmem [2][D];

   assign mrd[0] = bmem[0][ma[0][4:2]];
   assign mrd[1] = bmem[1][ma[1][4:2]];

   always @(posedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!reset) begin
            for (int i = 0; i < D; i++) bmem[k][i] <= W'(i);
         end else if (mwe[k]) begin
            bmem[k][ma[k][4:2]] <= mwd[k];
         end
      end
   end

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;

   task automatic chk(input int k, input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s inst%0d got %h expected %h at %0t", nm, k, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int           m_state [2];   // 0 free, 1 owned by port 0, 2 owned by port 1
   int           m_last  [2];   // last granted port
   bit           pv [2][2];     // response due next cycle, per port
   bit           pe [2][2];
   logic [W-1:0] pd [2][2];
   logic [W-1:0] mm [2][D];
   logic [W-1:0] exp_q [$];     // expected read data, filled by the stimulus for literal checks

   task automatic model_step(input int k);
      int           w;
      bit           e0, e1, err, we, lk;
      logic [W-1:0] a, wd;
      if (!reset) begin
         chk(k, "rst_rvalid0", W'(rv0[k]), 0);
         chk(k, "rst_rvalid1", W'(rv1[k]), 0);
         chk(k, "rst_rdata0", rd0[k], 0);
         chk(k, "rst_rdata1", rd1[k], 0);
         chk(k, "rst_err", W'({er1[k], er0[k]}), 0);
         chk(k, "rst_state", W'(dbg_st[k]), 0);
         m_state[k] = 0;
         m_last[k]  = 1;
         pv[k][0] = 1'b0; pv[k][1] = 1'b0;
         for (int i = 0; i < D; i++) mm[k][i] = W'(i);
      end else begin
         // responses for what was accepted in the previous cycle
         chk(k, "rvalid0", W'(rv0[k]), W'(pv[k][0]));
         chk(k, "rvalid1", W'(rv1[k]), W'(pv[k][1]));
         if (pv[k][0]) begin
            chk(k, "err0", W'(er0[k]), W'(pe[k][0]));
            chk(k, "rdata0", rd0[k], pd[k][0]);
         end
         if (pv[k][1]) begin
            chk(k, "err1", W'(er1[k]), W'(pe[k][1]));
            chk(k, "rdata1", rd1[k], pd[k][1]);
         end
         chk(k, "state", W'(dbg_st[k]), W'(m_state[k]));
         // who may and who does win this cycle
         e0 = m0_req && (m_state[k] != 2);
         e1 = m1_req && (m_state[k] != 1);
         if (e0 && e1) w = (k == 1 || m_last[k] == 1) ? 0 : 1;
         else if (e0)  w = 0;
         else if (e1)  w = 1;
         else          w = -1;
         chk(k, "gnt0", W'(g0[k]), W'(w == 0));
         chk(k, "gnt1", W'(g1[k]), W'(w == 1));
         pv[k][0] = 1'b0; pv[k][1] = 1'b0;
         if (w < 0) begin
            chk(k, "idle_mem_we", W'(mwe[k]), 0);
            chk(k, "idle_mem_a", ma[k], 0);
            chk(k, "idle_mem_wd", mwd[k], 0);
         end else begin
            a   = (w == 0) ? m0_addr  : m1_addr;
            wd  = (w == 0) ? m0_wdata : m1_wdata;
            we  = (w == 0) ? m0_we    : m1_we;
            lk  = (w == 0) ? m0_lock  : m1_lock;
            err = (a % 4 != 0) || (a / 4 >= D);
            chk(k, "mem_we", W'(mwe[k]), W'(we && !err));
            chk(k, "mem_a", ma[k], err ? 0 : a);
            chk(k, "mem_wd", mwd[k], err ? 0 : wd);
            pv[k][w] = 1'b1;
            pe[k][w] = err;
            pd[k][w] = (err || we) ? 0 : mm[k][a / 4];
            if (we && !err) mm[k][a / 4] = wd;
            m_last[k] = w;
            if (m_state[k] == 0) begin
               if (lk && !err) m_state[k] = w + 1;
            end else if (!lk || err) begin
               m_state[k] = 0;
            end
         end
      end
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) model_step(k);
   end

   // ---------------- driver tasks ----------------
   task automatic set_in(input bit r0, input bit we0, input logic [W-1:0] a0, input logic [W-1:0] wd0, input bit l0,
                         input bit r1, input bit we1, input logic [W-1:0] a1, input logic [W-1:0] wd1, input bit l1);
      m0_req = r0; m0_we = we0; m0_addr = a0; m0_wdata = wd0; m0_lock = l0;
      m1_req = r1; m1_we = we1; m1_addr = a1; m1_wdata = wd1; m1_lock = l1;
   endtask

   task automatic idle();
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- directed stimulus with literal expectations ----------------
   initial begin
      idle();
      reset = 1'b1;
      #2 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk(0, "lit_rst_mem_a", ma[0], 0);
      chk(0, "lit_rst_rvalid", W'(rv0[0]), 0);
      reset = 1'b1;

      // port 0 reads word 3
      set_in(1, 0, 32'h0C, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk(0, "lit_rd_gnt0", W'(g0[0]), 1);
      chk(0, "lit_rd_mem_a", ma[0], 32'h0C);
      chk(0, "lit_rd_mem_we", W'(mwe[0]), 0);
      tick();
      exp_q.push_back(32'd3);
      chk(0, "lit_rd_rvalid", W'(rv0[0]), 1);
      chk(0, "lit_rd_rdata", rd0[0], exp_q.pop_front());
      chk(0, "lit_rd_err", W'(er0[0]), 0);

      // port 1 writes, port 0 reads it back
      set_in(0, 0, 0, 0, 0, 1, 1, 32'h10, 32'hDEADBEEF, 0);
      tick();
      chk(0, "lit_wr_ack", W'(rv1[0]), 1);
      chk(0, "lit_wr_rdata", rd1[0], 0);
      set_in(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0);
      tick();
      exp_q.push_back(32'hDEADBEEF);
      chk(0, "lit_rb_rdata", rd0[0], exp_q.pop_front());

      // single port-1 access so port 1 is the last winner before contention
      set_in(0, 0, 0, 0, 0, 1, 0, 32'h00, 0, 0);
      tick();

      // both request for 4 cycles
      for (int c = 0; c < 4; c++) begin
         set_in(1, 0, 32'h00, 0, 0, 1, 0, 32'h04, 0, 0);
         #1;
         chk(0, "lit_rr_gnt0", W'(g0[0]), W'(c % 2 == 0));
         chk(0, "lit_rr_gnt1", W'(g1[0]), W'(c % 2 == 1));
         chk(1, "lit_fp_gnt0", W'(g0[1]), 1);
         chk(1, "lit_fp_gnt1", W'(g1[1]), 0);
         tick();
      end

      // locked read-modify-write on port 0 with port 1 waiting
      set_in(1, 0, 32'h04, 0, 1, 1, 0, 32'h08, 0, 0);
      #1;
      chk(0, "lit_lk_a_gnt0", W'(g0[0]), 1);
      chk(0, "lit_lk_a_gnt1", W'(g1[0]), 0);
      tick();
      chk(0, "lit_lk_state", W'(dbg_st[0]), W'(LOCK0));
      chk(0, "lit_lk_rdata", rd0[0], 32'd1);
      set_in(1, 1, 32'h04, 32'hA5A50004, 0, 1, 0, 32'h08, 0, 0);
      #1;
      chk(0, "lit_lk_b_gnt1", W'(g1[0]), 0);
      chk(1, "lit_lk_b_gnt1", W'(g1[1]), 0);
      tick();
      set_in(0, 0, 0, 0, 0, 1, 0, 32'h08, 0, 0);
      #1;
      chk(0, "lit_lk_c_gnt1", W'(g1[0]), 1);
      chk(1, "lit_lk_c_gnt1", W'(g1[1]), 1);
      tick();
      idle();
      tick();

      // faulting accesses from port 1
      set_in(0, 0, 0, 0, 0, 1, 1, 32'h20, 32'h12345678, 1);
      #1;
      chk(0, "lit_oor_gnt1", W'(g1[0]), 1);
      chk(0, "lit_oor_mem_we", W'(mwe[0]), 0);
      chk(0, "lit_oor_mem_a", ma[0], 0);
      tick();
      chk(0, "lit_oor_err", W'(er1[0]), 1);
      chk(0, "lit_oor_rdata", rd1[0], 0);
      chk(0, "lit_oor_nolock", W'(dbg_st[0]), W'(ARB));
      set_in(0, 0, 0, 0, 0, 1, 1, 32'h06, 32'h87654321, 0);
      #1;
      chk(0, "lit_mis_mem_we", W'(mwe[0]), 0);
      tick();
      chk(0, "lit_mis_err", W'(er1[0]), 1);
      chk(0, "lit_mis_rdata", rd1[0], 0);
      idle();
      tick();
      chk(0, "lit_mem0_kept", bmem[0][0], 0);
      chk(0, "lit_mem1_kept", bmem[0][1], 32'hA5A50004);
      set_in(0, 0, 0, 0, 0, 1, 0, 32'h04, 0, 0);
      tick();
      chk(0, "lit_mem1_read", rd1[0], 32'hA5A50004);

      // reset in the cycle after a locked port-0 read is accepted
      set_in(1, 0, 32'h08, 0, 1, 0, 0, 0, 0, 0);
      tick();
      reset = 1'b0;
      idle();
      #1;
      chk(0, "lit_mid_rvalid", W'(rv0[0]), 0);
      chk(0, "lit_mid_state", W'(dbg_st[0]), W'(ARB));
      chk(0, "lit_mid_mem_a", ma[0], 0);
      tick();
      tick();
      reset = 1'b1;
      set_in(0, 0, 0, 0, 0, 1, 0, 32'h0C, 0, 0);
      #1;
      chk(0, "lit_post_gnt1", W'(g1[0]), 1);
      tick();
      chk(0, "lit_post_rvalid0", W'(rv0[0]), 0);
      chk(0, "lit_post_rdata1", rd1[0], 32'd3);
      idle();
      tick();
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
